// File: rtl/event_pkg.sv
// Shared definitions for the event ack/nack path: message field layout,
// readout byte limit, message type encoding and counter helper.
package event_pkg;

   localparam int MAX_BYTES_DEFAULT = 459008;

   typedef enum logic {
      MSG_ACK  = 1'b0,
      MSG_NACK = 1'b1
   } msg_type_e;

   // Bit layout of the 48-bit ack/nack word, MSB first.
   typedef struct packed {
      logic        allow;       // [47]
      logic        full_event;  // [46]
      logic [2:0]  rsvd_hi;     // [45:43]
      logic [10:0] length;      // [42:32] qwords
      logic [11:0] upper_addr;  // [31:20]
      logic        rsvd_lo;     // [19]
      logic [18:0] offset;      // [18:0] bytes
   } event_msg_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         return value;
      end else begin
         return value + 16'd1;
      end
   endfunction

endpackage

// File: rtl/event_nack_fifo.sv
// Synchronous first-word-fall-through FIFO holding validated nacks.
// Writes when full and reads when empty are ignored.
module event_nack_fifo
   import event_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 48
) (
   input  logic                     memclk,
   input  logic                     aresetn,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occ;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (occ == (AW+1)'(DEPTH));
   assign empty   = (occ == (AW+1)'(0));
   assign count   = occ;
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge memclk) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge memclk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/event_ack_nack_splitter.sv
// Splits the combined ack/nack message stream: acks go to a one-deep
// broadcast register, nacks are range-checked and queued for readout.
module event_ack_nack_splitter
   import event_pkg::*;
#(
   parameter int NACK_DEPTH = 16,
   parameter int MAX_BYTES  = MAX_BYTES_DEFAULT
) (
   input  logic        memclk,
   input  logic        aresetn,
   input  logic [47:0] s_msg_tdata,
   input  logic        s_msg_tuser,
   input  logic        s_msg_tvalid,
   output logic        s_msg_tready,
   output logic [47:0] m_ack_tdata,
   output logic        m_ack_tvalid,
   input  logic        m_ack_tready,
   output logic [47:0] m_nack_tdata,
   output logic        m_nack_tvalid,
   input  logic        m_nack_tready,
   output logic        allow_o,
   output logic [15:0] ack_count_o,
   output logic [15:0] nack_count_o,
   output logic [15:0] drop_count_o
);

   localparam logic [19:0] BYTE_LIMIT = 20'(MAX_BYTES);

   event_msg_t  msg;
   logic        is_nack;
   logic        ack_hs;
   logic        nack_hs;
   logic        nack_bad;
   logic [19:0] end_byte;
   logic        fifo_full;
   logic        fifo_empty;
   logic [$clog2(NACK_DEPTH):0] fifo_count_unused;

   assign msg      = event_msg_t'(s_msg_tdata);
   assign is_nack  = (s_msg_tuser == MSG_NACK);
   assign ack_hs   = s_msg_tvalid && s_msg_tready && !is_nack;
   assign nack_hs  = s_msg_tvalid && s_msg_tready && is_nack;

   // Both terms fit comfortably in 20 bits, so the sum cannot overflow.
   assign end_byte = 20'(msg.offset) + 20'({msg.length, 3'b000});
   assign nack_bad = !msg.full_event &&
                     ((msg.length == 11'd0) ||
                      (msg.offset[2:0] != 3'b000) ||
                      (end_byte > BYTE_LIMIT));

   // Input ready depends on the destination selected by the message type.
   always_comb begin
      s_msg_tready = 1'b0;
      if (!aresetn) begin
         s_msg_tready = 1'b0;
      end else if (is_nack) begin
         s_msg_tready = !fifo_full;
      end else begin
         s_msg_tready = !m_ack_tvalid || m_ack_tready;
      end
   end

   event_nack_fifo #(
      .DEPTH (NACK_DEPTH),
      .WIDTH (48)
   ) u_nack_fifo (
      .memclk  (memclk),
      .aresetn (aresetn),
      .wr_en   (nack_hs && !nack_bad),
      .wr_data (s_msg_tdata),
      .rd_en   (m_nack_tready),
      .rd_data (m_nack_tdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count_unused)
   );

   assign m_nack_tvalid = !fifo_empty;

   // Ack valid and allow pulse; allow ignores downstream backpressure.
   always_ff @(posedge memclk) begin
      if (!aresetn) begin
         m_ack_tvalid <= 1'b0;
         allow_o      <= 1'b0;
      end else begin
         allow_o <= ack_hs && msg.allow;
         if (ack_hs) begin
            m_ack_tvalid <= 1'b1;
         end else if (m_ack_tready) begin
            m_ack_tvalid <= 1'b0;
         end
      end
   end

   // Ack payload register.
   always_ff @(posedge memclk) begin
      if (ack_hs) begin
         m_ack_tdata <= s_msg_tdata;
      end
   end

   // Saturating statistics; dropped nacks count as accepted nacks too.
   always_ff @(posedge memclk) begin
      if (!aresetn) begin
         ack_count_o  <= 16'd0;
         nack_count_o <= 16'd0;
         drop_count_o <= 16'd0;
      end else begin
         if (ack_hs) begin
            ack_count_o <= sat_inc16(ack_count_o);
         end
         if (nack_hs) begin
            nack_count_o <= sat_inc16(nack_count_o);
         end
         if (nack_hs && nack_bad) begin
            drop_count_o <= sat_inc16(drop_count_o);
         end
      end
   end

endmodule

// File: tb/tb_event_ack_nack_splitter.sv
// Bench for event_ack_nack_splitter: directed vector table, corner-case
// sequences and randomized traffic checked against a queue-based model.
module tb_event_ack_nack_splitter;

   localparam int DEPTH = 16;
   localparam int MAXB  = 459008;

   logic        memclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [47:0] s_msg_tdata = '0;
   logic        s_msg_tuser = 1'b0;
   logic        s_msg_tvalid = 1'b0;
   logic        s_msg_tready;
   logic [47:0] m_ack_tdata;
   logic        m_ack_tvalid;
   logic        m_ack_tready = 1'b0;
   logic [47:0] m_nack_tdata;
   logic        m_nack_tvalid;
   logic        m_nack_tready = 1'b0;
   logic        allow_o;
   logic [15:0] ack_count_o, nack_count_o, drop_count_o;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [47:0] nq[$];
   logic        m_ack_v = 1'b0;
   logic [47:0] m_ack_d = '0;
   logic        m_allow = 1'b0;
   int          m_acks = 0, m_nacks = 0, m_drops = 0;

   always #5 memclk = ~memclk;

   event_ack_nack_splitter dut (
      .memclk        (memclk),
      .aresetn       (aresetn),
      .s_msg_tdata   (s_msg_tdata),
      .s_msg_tuser   (s_msg_tuser),
      .s_msg_tvalid  (s_msg_tvalid),
      .s_msg_tready  (s_msg_tready),
      .m_ack_tdata   (m_ack_tdata),
      .m_ack_tvalid  (m_ack_tvalid),
      .m_ack_tready  (m_ack_tready),
      .m_nack_tdata  (m_nack_tdata),
      .m_nack_tvalid (m_nack_tvalid),
      .m_nack_tready (m_nack_tready),
      .allow_o       (allow_o),
      .ack_count_o   (ack_count_o),
      .nack_count_o  (nack_count_o),
      .drop_count_o  (drop_count_o)
   );

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] mk(input logic a, input logic f, input int len, input int ofs);
      logic [47:0] m;
      m = '0;
      m[47] = a;
      m[46] = f;
      m[42:32] = 11'(len);
      m[18:0] = 19'(ofs);
      return m;
   endfunction

   function automatic bit nack_ok(input logic [47:0] d);
      int len, ofs;
      len = int'(d[42:32]);
      ofs = int'(d[18:0]);
      if (d[46]) return 1'b1;
      return (len != 0) && (ofs % 8 == 0) && (ofs + 8 * len <= MAXB);
   endfunction

   function automatic int sat(input int x);
      return (x >= 65535) ? 65535 : x + 1;
   endfunction

   task automatic model_update(input bit hs, input logic u, input logic [47:0] d,
                               input logic ar, input logic nr, input logic rn);
      if (!rn) begin
         nq.delete();
         m_ack_v = 1'b0;
         m_allow = 1'b0;
         m_acks = 0; m_nacks = 0; m_drops = 0;
      end else begin
         if (nq.size() != 0 && nr) void'(nq.pop_front());
         if (hs && u) begin
            m_nacks = sat(m_nacks);
            if (nack_ok(d)) nq.push_back(d);
            else m_drops = sat(m_drops);
         end
         if (hs && !u) begin
            m_ack_v = 1'b1;
            m_ack_d = d;
            m_acks = sat(m_acks);
         end else if (ar) begin
            m_ack_v = 1'b0;
         end
         m_allow = hs && !u && d[47];
      end
   endtask

   task automatic check_outputs();
      chk("m_ack_tvalid", m_ack_tvalid, m_ack_v);
      if (m_ack_v) chk("m_ack_tdata", m_ack_tdata, m_ack_d);
      chk("m_nack_tvalid", m_nack_tvalid, nq.size() != 0);
      if (nq.size() != 0) chk("m_nack_tdata", m_nack_tdata, nq[0]);
      chk("allow_o", allow_o, m_allow);
      chk("ack_count_o", ack_count_o, 48'(m_acks));
      chk("nack_count_o", nack_count_o, 48'(m_nacks));
      chk("drop_count_o", drop_count_o, 48'(m_drops));
   endtask

   // One clock cycle: drive at negedge, check ready, clock, update model, check outputs.
   task automatic cycle(input logic v, input logic u, input logic [47:0] d,
                        input logic ar, input logic nr, input logic rn,
                        output logic acc, output logic ohs, output logic [47:0] od);
      logic exp_rdy;
      s_msg_tvalid = v; s_msg_tuser = u; s_msg_tdata = d;
      m_ack_tready = ar; m_nack_tready = nr; aresetn = rn;
      #1;
      exp_rdy = rn && (u ? (nq.size() < DEPTH) : (!m_ack_v || ar));
      chk("s_msg_tready", s_msg_tready, exp_rdy);
      acc = v && s_msg_tready;
      ohs = m_nack_tvalid && nr;
      od  = m_nack_tdata;
      @(posedge memclk);
      model_update(v && exp_rdy, u, d, ar, nr, rn);
      @(negedge memclk);
      check_outputs();
   endtask

   function automatic logic [47:0] rand_msg();
      logic [47:0] d;
      int mode;
      d = {16'($urandom), $urandom};
      mode = int'($urandom_range(3, 0));
      case (mode)
         1: begin
            d[42:32] = 11'($urandom_range(40, 0));
            d[18:0]  = 19'(458752 + 8 * int'($urandom_range(31, 0)));
            d[46]    = 1'b0;
         end
         2: begin
            d[42:32] = 11'($urandom_range(100, 1));
            d[18:0]  = 19'(8 * int'($urandom_range(1000, 0)));
         end
         3: d[42:32] = 11'd0;
         default: ;
      endcase
      return d;
   endfunction

   typedef struct {
      logic        user;
      logic [47:0] data;
      logic        exp_q;
      logic        exp_allow;
   } vec_t;

   initial begin
      vec_t        vecs[12];
      logic [47:0] items[20];
      logic        acc, ohs;
      logic [47:0] od;
      int          e_acks, e_nacks, e_drops, idx, got;

      vecs[0]  = '{1'b0, 48'h8000_0012_3000, 1'b1, 1'b1};
      vecs[1]  = '{1'b0, 48'h0000_0012_3000, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, mk(0, 0, 4, 458752), 1'b1, 1'b0};
      vecs[3]  = '{1'b1, mk(0, 0, 40, 458752), 1'b0, 1'b0};
      vecs[4]  = '{1'b1, mk(0, 0, 32, 458752), 1'b1, 1'b0};
      vecs[5]  = '{1'b1, mk(0, 0, 33, 458752), 1'b0, 1'b0};
      vecs[6]  = '{1'b1, mk(0, 0, 0, 0), 1'b0, 1'b0};
      vecs[7]  = '{1'b1, mk(0, 0, 1, 4), 1'b0, 1'b0};
      vecs[8]  = '{1'b1, mk(1, 1, 0, 0), 1'b1, 1'b0};
      vecs[9]  = '{1'b1, mk(0, 1, 2047, 524287), 1'b1, 1'b0};
      vecs[10] = '{1'b1, mk(1, 0, 1, 8), 1'b1, 1'b0};
      vecs[11] = '{1'b1, mk(0, 0, 2047, 0), 1'b1, 1'b0};

      // reset
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, acc, ohs, od);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, acc, ohs, od);
      chk("reset_ack_valid", m_ack_tvalid, 1'b0);
      chk("reset_nack_valid", m_nack_tvalid, 1'b0);
      chk("reset_ack_count", ack_count_o, 48'd0);

      // directed vector table
      e_acks = 0; e_nacks = 0; e_drops = 0;
      foreach (vecs[i]) begin
         cycle(1'b1, vecs[i].user, vecs[i].data, 1'b1, 1'b1, 1'b1, acc, ohs, od);
         chk("vec_accept", acc, 1'b1);
         if (vecs[i].user == 1'b0) begin
            e_acks++;
            chk("vec_ack_valid", m_ack_tvalid, 1'b1);
            chk("vec_ack_data", m_ack_tdata, vecs[i].data);
         end else begin
            e_nacks++;
            if (!vecs[i].exp_q) e_drops++;
            chk("vec_nack_valid", m_nack_tvalid, vecs[i].exp_q);
            if (vecs[i].exp_q) chk("vec_nack_data", m_nack_tdata, vecs[i].data);
         end
         chk("vec_allow", allow_o, vecs[i].exp_allow);
         chk("vec_ack_count", ack_count_o, 48'(e_acks));
         chk("vec_nack_count", nack_count_o, 48'(e_nacks));
         chk("vec_drop_count", drop_count_o, 48'(e_drops));
      end
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, acc, ohs, od);
      chk("allow_single_pulse", allow_o, 1'b0);

      // mid-stream reset with held ack and queued nacks
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 1'b1, mk(0, 0, 1, 8 * i), 1'b0, 1'b0, 1'b1, acc, ohs, od);
      cycle(1'b1, 1'b0, 48'h8000_0000_0001, 1'b0, 1'b0, 1'b1, acc, ohs, od);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, acc, ohs, od);
      chk("pre_reset_ack_held", m_ack_tvalid, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, acc, ohs, od);
      chk("rst_ack_valid", m_ack_tvalid, 1'b0);
      chk("rst_nack_valid", m_nack_tvalid, 1'b0);
      chk("rst_counts", {ack_count_o, nack_count_o, drop_count_o}, 48'd0);
      cycle(1'b1, 1'b1, mk(0, 0, 1, 0), 1'b1, 1'b0, 1'b1, acc, ohs, od);
      chk("post_reset_accept", acc, 1'b1);

      // fill the queue while blocked, then drain and check ordering
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, acc, ohs, od);
      foreach (items[i]) items[i] = mk(0, 0, 1 + i, 8 * i);
      idx = 0; got = 0;
      for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
         cycle(idx < 20, 1'b1, items[(idx < 20) ? idx : 0], 1'b1, cyc >= 20, 1'b1, acc, ohs, od);
         if (acc) idx++;
         if (cyc == 19) begin
            chk("stall_accepted", 48'(idx), 48'd16);
            chk("stall_tready", s_msg_tready, 1'b0);
         end
         if (ohs) begin
            chk("drain_order", od, items[got]);
            got++;
         end
      end
      chk("drain_total", 48'(got), 48'd20);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(3, 0) != 0, 1'($urandom), rand_msg(),
               $urandom_range(3, 0) != 0, (i % 300 < 60) ? 1'b0 : ($urandom_range(2, 0) != 0),
               $urandom_range(199, 0) != 0, acc, ohs, od);

      // ack counter saturation
      for (int i = 0; i < 70000; i++)
         cycle(1'b1, 1'b0, 48'(i), 1'b1, 1'b1, 1'b1, acc, ohs, od);
      chk("ack_count_saturated", ack_count_o, 48'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/event_ack_nack_splitter.md
EVENT_ACK_NACK_SPLITTER -- requirements
Module: event_ack_nack_splitter

Interface
REQ-001 Parameter NACK_DEPTH, default 16, nack queue depth in entries; power of 2, 4..64.
REQ-002 Parameter MAX_BYTES, default 459008, maximum event readout bytes; nacks must fit inside this limit.
REQ-003 memclk  in  1  clock; all ports are synchronous to memclk.
REQ-004 aresetn  in  1  reset; synchronous, active-low.
REQ-005 s_msg_tdata  in  48  ack/nack word: [47] allow, [46] full_event, [42:32] length in qwords, [31:20] upper_addr, [18:0] byte offset.
REQ-006 s_msg_tuser  in  1  message type; 0 = ack, 1 = nack.
REQ-007 s_msg_tvalid / s_msg_tready  in / out  1 / 1  input handshake.
REQ-008 m_ack_tdata / m_ack_tvalid / m_ack_tready  out / out / in  48 / 1 / 1  ack broadcast stream to the request generators and the header accumulator.
REQ-009 m_nack_tdata / m_nack_tvalid / m_nack_tready  out / out / in  48 / 1 / 1  validated nack stream to the readout generator.
REQ-010 allow_o  out  1  single-cycle flag, one pulse per accepted ack with [47] set.
REQ-011 ack_count_o, nack_count_o, drop_count_o  out  16 each  saturating statistics counters.

Function
REQ-012 s_msg_tready SHALL be combinational: for tuser=0, asserted when (!m_ack_tvalid || m_ack_tready); for tuser=1, asserted when the nack queue is not full. It SHALL be low while aresetn is low.
REQ-013 Accepted acks SHALL load the m_ack register with tdata unchanged, giving a 1-cycle latency; m_ack_tvalid SHALL hold until m_ack_tready. Back-to-back acks at full rate SHALL be sustained while m_ack_tready is held high.
REQ-014 allow_o SHALL pulse high exactly 1 cycle after the handshake of an ack with [47]=1, independent of m_ack_tready.
REQ-015 Bit [47] of nacks SHALL be ignored: no allow_o pulse, and the bit is forwarded unchanged.
REQ-016 Nack validation applies only when [46]=0. A nack SHALL be dropped if any of these holds: length == 0; offset[2:0] != 0; offset + 8*length > MAX_BYTES. The sum SHALL be computed at 20-bit width with no overflow.
REQ-017 Nacks with [46]=1 SHALL be queued without checks.
REQ-018 A dropped nack SHALL still be handshaken (consumed), SHALL increment drop_count_o, and SHALL NOT be queued.
REQ-019 Valid nacks SHALL be written into a FIFO of NACK_DEPTH entries in first-in, first-out order; m_nack_tvalid = FIFO non-empty; m_nack_tdata = FIFO head (first-word-fall-through).
REQ-020 Latency from nack input handshake to m_nack_tvalid SHALL be 1 cycle when the queue is empty.
REQ-021 Full queue: the nack input stalls (tready low) and no entry is lost. Because of REQ-012, a pending nack at the input blocks any subsequent ack.
REQ-022 A simultaneous FIFO write and read SHALL leave the occupancy unchanged; when full, a read and a write in the same cycle SHALL NOT be allowed (tready is evaluated on the pre-read occupancy).
REQ-023 ack_count_o SHALL increment per accepted ack; nack_count_o SHALL increment per accepted nack, including dropped nacks. All counters saturate at 0xFFFF and never wrap.
REQ-024 The FIFO pointers SHALL wrap modulo NACK_DEPTH; occupancy is tracked with a log2(NACK_DEPTH)+1 bit count.

Reset
REQ-025 While aresetn is low, on each memclk edge: m_ack_tvalid=0, m_nack_tvalid=0 (queue emptied), allow_o=0, all counters=0, s_msg_tready=0.
REQ-026 A reset asserted mid-stream SHALL discard the held ack and all queued nacks. The first handshake is possible in the cycle after aresetn returns high.
REQ-027 Data registers need no reset; their contents are don't-care while the corresponding valid is low.

Structure
REQ-028 The shared package event_pkg SHALL hold the field positions for allow, full_event, length, upper_addr and offset, the MAX_BYTES default (459008), and the ack/nack tuser encoding.
REQ-029 The nack queue SHALL be a sub-module, event_nack_fifo: synchronous, FWFT, 48-bit, parameterised depth, with full/empty/count outputs.
REQ-030 The top-level SHALL contain only the type demux, the validator, the ack register, the allow pulse and the counters.

Verification
REQ-031 Ack 0x8000_0012_3000 with tuser=0 and ack_tready=1 -> m_ack carries the same word 1 cycle later; allow_o pulses once; ack_count_o=1.
REQ-032 Nack with [46]=0, length=4, offset=0x70000 (458752) -> the sum 458784 is within limit, so the nack is queued and m_nack_tvalid rises 1 cycle later. Length=40 at the same offset (sum 459072) -> dropped; drop_count_o=1; nack_count_o=2.
REQ-033 20 valid nacks with m_nack_tready=0 -> 16 queued, s_msg_tready goes low; then release tready -> all 20 emerge in order with none lost.
REQ-034 Nack with [47]=1, [46]=1, length=0 -> queued unchanged; no allow_o pulse.
REQ-035 Queue 5 nacks, hold ack output stalled, pulse aresetn low for 1 cycle -> all valids low and counters 0; the next nack is accepted in the first cycle after release.
REQ-036 Drive 70000 acks -> ack_count_o holds at 0xFFFF.
